// File: rtl/apb_slave_pkg.sv
`default_nettype none
// ============================================================================
// apb_slave_pkg : shared state encoding and wait-counter width for apb_wait_slave
// Revision: 1.0
// ============================================================================
package apb_slave_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// apb_slave_mem : DEPTH x DW storage, synchronous write, registered read
// Revision: 1.0
// ============================================================================
module apb_slave_mem
   import apb_slave_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 64,
   parameter int MW    = 6
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [MW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic          i_rzero,
   input  logic [MW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // Storage array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/apb_wait_slave.sv
`default_nettype none
// ============================================================================
// apb_wait_slave : APB slave with a fixed number of PREADY wait states
// Revision: 1.0
// ============================================================================
module apb_wait_slave
   import apb_slave_pkg::*;
#(
   parameter int AW    = 9,
   parameter int DW    = 8,
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
)(
   input  logic          pclk,
   input  logic          presetn,
   input  logic          psel,
   input  logic          penable,
   input  logic          pwrite,
   input  logic [AW-1:0] paddr,
   input  logic [DW-1:0] pwdata,
   output logic [DW-1:0] prdata,
   output logic          pready,
   output logic          pslverr
);

   localparam int IXW = AW - 1;
   localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(WAIT);

   apb_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_write;
   logic             r_err;
   logic [MW-1:0]    r_addr;
   logic [DW-1:0]    r_wdata;

   logic [IXW-1:0]   w_idx;
   logic             w_idx_err;
   logic             w_unused_sel;
   logic             w_pready;
   logic             w_capture;
   logic             w_commit;
   logic             w_rd_load;

   assign w_idx        = paddr[IXW-1:0];
   assign w_unused_sel = paddr[AW-1];
   assign w_idx_err    = (32'(w_idx) >= DEPTH);

   assign w_pready  = (r_state == ACCESS) && (r_cnt == '0);
   assign w_capture = psel && !penable && ((r_state == IDLE) || w_pready);
   assign w_commit  = w_pready && r_write && !r_err;

   // Read data must be in place for the whole completion cycle, so it is
   // loaded on the edge that enters that cycle.
   assign w_rd_load = psel && !r_write &&
                      (((r_state == SETUP) && penable && (c_wait_load == '0)) ||
                       ((r_state == ACCESS) && (r_cnt == CNT_W'(1))));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (psel && !penable) begin
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               if (!psel) begin
                  r_state <= IDLE;
               end else if (penable) begin
                  r_state <= ACCESS;
                  r_cnt   <= c_wait_load;
               end
            end
            ACCESS: begin
               if (r_cnt != '0) begin
                  if (!psel) begin
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end else if (psel && !penable) begin
                  r_state <= SETUP;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_capture) begin
         r_write <= pwrite;
         r_err   <= w_idx_err;
         r_addr  <= w_idx[MW-1:0];
         r_wdata <= pwdata;
      end
   end

   apb_slave_mem #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .MW    (MW)
   ) u_mem (
      .clk     (pclk),
      .rst_n   (presetn),
      .i_we    (w_commit),
      .i_waddr (r_addr),
      .i_wdata (r_wdata),
      .i_re    (w_rd_load),
      .i_rzero (r_err),
      .i_raddr (r_addr),
      .o_rdata (prdata)
   );

   assign pready  = w_pready;
   assign pslverr = w_pready && r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_wait_slave.sv
`default_nettype none
// ============================================================================
// tb_apb_wait_slave : two slaves (WAIT=2 and WAIT=0) driven from a vector table
// Revision: 1.0
// ============================================================================
module tb_apb_wait_slave;
   import apb_slave_pkg::*;

   localparam int AW    = 9;
   localparam int DW    = 8;
   localparam int DEPTH = 64;

   typedef struct {
      int k;
      bit wr;
      int addr;
      int data;
      bit b2b;
   } vec_t;

   typedef struct {
      int            k;
      bit            err;
      logic [DW-1:0] rdata;
      int            waits;
   } sb_t;

   logic          clk = 1'b0;
   logic          presetn;
   logic          psel    [2];
   logic          penable [2];
   logic          pwrite  [2];
   logic [AW-1:0] paddr   [2];
   logic [DW-1:0] pwdata  [2];
   logic [DW-1:0] prdata  [2];
   logic          pready  [2];
   logic          pslverr [2];

   logic [DW-1:0] ref_mem  [2][256];
   logic [DW-1:0] ref_last [2];
   sb_t           sbq[$];
   vec_t          vt[16];
   int            n_chk  = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;

   apb_wait_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT(2)) u_w2 (
      .pclk(clk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
   );

   apb_wait_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT(0)) u_w0 (
      .pclk(clk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic idle(input int k);
      psel[k]    = 1'b0;
      penable[k] = 1'b0;
   endtask

   // Present a SETUP request; when push is set, the model predicts the outcome.
   task automatic start_setup(input int k, input bit wr, input int addr, input int data,
                              input bit push);
      sb_t e;
      int  idx;
      idx        = addr & 255;
      psel[k]    = 1'b1;
      penable[k] = 1'b0;
      pwrite[k]  = wr;
      paddr[k]   = AW'(addr);
      pwdata[k]  = DW'(data);
      if (push) begin
         e.k     = k;
         e.err   = (idx >= DEPTH);
         e.waits = (k == 0) ? 2 : 0;
         if (wr) begin
            if (!e.err) ref_mem[k][idx] = DW'(data);
            e.rdata = ref_last[k];
         end else begin
            e.rdata     = e.err ? '0 : ref_mem[k][idx];
            ref_last[k] = e.rdata;
         end
         sbq.push_back(e);
      end
   endtask

   // Enter ACCESS and wait (bounded) for pready, then score the completion.
   task automatic finish(input int k);
      sb_t e;
      int  waits;
      bit  done;
      waits = 0;
      done  = 1'b0;
      @(negedge clk);
      penable[k] = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (pready[k] === 1'b1) done = 1'b1;
         else waits++;
      end
      e = sbq.pop_front();
      chk($sformatf("pready_timeout[%0d]", k), 32'(done), 32'd1);
      chk($sformatf("wait_cycles[%0d]", k), waits, e.waits);
      chk($sformatf("pslverr[%0d]", k), 32'(pslverr[k]), 32'(e.err));
      chk($sformatf("prdata[%0d]", k), 32'(prdata[k]), 32'(e.rdata));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{0, 1'b1, 5,     'hA5, 1'b0};
      vt[1]  = '{0, 1'b0, 5,     0,    1'b1};
      vt[2]  = '{1, 1'b1, 0,     'h11, 1'b0};
      vt[3]  = '{1, 1'b1, 1,     'h22, 1'b1};
      vt[4]  = '{1, 1'b0, 0,     0,    1'b1};
      vt[5]  = '{1, 1'b0, 1,     0,    1'b1};
      vt[6]  = '{0, 1'b1, 6,     'h5A, 1'b0};
      vt[7]  = '{0, 1'b1, 70,    'hFF, 1'b0};
      vt[8]  = '{0, 1'b0, 70,    0,    1'b0};
      vt[9]  = '{0, 1'b0, 6,     0,    1'b0};
      vt[10] = '{0, 1'b0, 'h105, 0,    1'b1};
      vt[11] = '{0, 1'b1, 9,     'h77, 1'b0};
      vt[12] = '{0, 1'b1, 63,    'hC3, 1'b0};
      vt[13] = '{0, 1'b0, 63,    0,    1'b1};
      vt[14] = '{0, 1'b1, 64,    'h44, 1'b1};
      vt[15] = '{0, 1'b0, 63,    0,    1'b1};

      presetn = 1'b0;
      for (int k = 0; k < 2; k++) begin
         idle(k);
         pwrite[k]   = 1'b0;
         paddr[k]    = '0;
         pwdata[k]   = '0;
         ref_last[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset_pready[%0d]", k), 32'(pready[k]), 32'd0);
         chk($sformatf("reset_pslverr[%0d]", k), 32'(pslverr[k]), 32'd0);
         chk($sformatf("reset_prdata[%0d]", k), 32'(prdata[k]), 32'd0);
      end
      chk("reset_state", 32'(u_w2.r_state), 32'(IDLE));
      presetn = 1'b1;
      @(negedge clk);

      // penable straight from IDLE must not start a transfer
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
      paddr[0] = AW'(5); pwdata[0] = 8'hEE;
      repeat (3) begin
         @(negedge clk);
         chk("idle_penable_pready", 32'(pready[0]), 32'd0);
      end
      chk("idle_penable_state", 32'(u_w2.r_state), 32'(IDLE));
      idle(0);

      for (int i = 0; i < 16; i++) begin
         if (!vt[i].b2b) begin
            if (i > 0) idle(vt[i-1].k);
            @(negedge clk);
         end
         start_setup(vt[i].k, vt[i].wr, vt[i].addr, vt[i].data, 1'b1);
         finish(vt[i].k);
      end
      idle(vt[15].k);

      // psel dropped in the second ACCESS cycle of a write
      @(negedge clk);
      start_setup(0, 1'b1, 9, 'h3C, 1'b0);
      @(negedge clk);
      penable[0] = 1'b1;
      @(negedge clk);
      chk("abort_acc1_pready", 32'(pready[0]), 32'd0);
      @(negedge clk);
      chk("abort_acc2_pready", 32'(pready[0]), 32'd0);
      idle(0);
      @(negedge clk);
      chk("abort_pready", 32'(pready[0]), 32'd0);
      chk("abort_state", 32'(u_w2.r_state), 32'(IDLE));
      start_setup(0, 1'b0, 9, 0, 1'b1);
      finish(0);
      idle(0);

      // reset pulse in the middle of ACCESS
      @(negedge clk);
      start_setup(0, 1'b1, 9, 'h99, 1'b0);
      @(negedge clk);
      penable[0] = 1'b1;
      @(negedge clk);
      presetn = 1'b0;
      #1;
      chk("rst_mid_pready", 32'(pready[0]), 32'd0);
      chk("rst_mid_pslverr", 32'(pslverr[0]), 32'd0);
      chk("rst_mid_prdata0", 32'(prdata[0]), 32'd0);
      chk("rst_mid_prdata1", 32'(prdata[1]), 32'd0);
      chk("rst_mid_state", 32'(u_w2.r_state), 32'(IDLE));
      ref_last[0] = '0;
      ref_last[1] = '0;
      idle(0);
      idle(1);
      @(negedge clk);
      presetn = 1'b1;
      @(negedge clk);
      start_setup(0, 1'b0, 9, 0, 1'b1);
      finish(0);
      idle(0);
      @(negedge clk);
      start_setup(1, 1'b0, 1, 0, 1'b1);
      finish(1);
      idle(1);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
